// File: rtl/mel_filter_acc.sv
// Mel filterbank accumulator.
// Each power-spectrum bin contributes up to two weighted products to the
// filter accumulators. The filters live in two ping-pong banks: the write bank
// collects the current frame while the read bank streams out the previous one.
// The flow is a two-stage pipeline. S1 registers the products; S2 does the
// saturating read-modify-write into the write bank and handles bank swaps.
//
// Output handshake: a beat transfers on any rising edge where do_valid and
// do_ready are both high. Once do_valid is raised it stays high until its beat
// transfers, and data_o, do_mel_idx and do_last do not change in the meantime.
// do_valid never depends combinationally on do_ready.
module mel_filter_acc #(
  parameter int I_BW    = 27,
  parameter int COEF_BW = 27,
  parameter int FRAC    = 26,
  parameter int ACC_BW  = 32,
  parameter int N_MEL   = 64,
  parameter int IDX_BW  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     di_en,
  input  logic signed [I_BW-1:0]   data_i,
  input  logic                     is_first_in,
  input  logic                     is_last_in,
  input  logic [1:0]               coef_num,
  input  logic [IDX_BW-1:0]        coef_idx1,
  input  logic [IDX_BW-1:0]        coef_idx2,
  input  logic [COEF_BW-1:0]       coef1,
  input  logic [COEF_BW-1:0]       coef2,
  output logic                     do_valid,
  input  logic                     do_ready,
  output logic signed [ACC_BW-1:0] data_o,
  output logic [IDX_BW-1:0]        do_mel_idx,
  output logic                     do_last,
  output logic [15:0]              frame_cnt,
  output logic                     ovf,
  output logic                     sat,
  input  logic                     clr_flags
);

  // Full signed product width: the coefficient gets an extra zero sign bit.
  localparam int PROD_BW = I_BW + COEF_BW + 1;
  // Product width after dropping the fraction bits.
  localparam int PW      = PROD_BW - FRAC;
  // Sum width: room for the accumulator plus two products without wrapping.
  localparam int SUM_BW  = ((ACC_BW > PW) ? ACC_BW : PW) + 2;

  localparam logic signed [SUM_BW-1:0] ACC_MAX = SUM_BW'({1'b0, {(ACC_BW-1){1'b1}}});
  localparam logic signed [SUM_BW-1:0] ACC_MIN = ~ACC_MAX;

  typedef enum logic [1:0] {
    RD_IDLE  = 2'd0,
    RD_START = 2'd1,
    RD_READ  = 2'd2
  } rd_state_t;

  // Readout state. It is kept as a named signal so checkers can observe it.
  rd_state_t rd_state;

  // Two accumulator banks. wr_sel picks the write bank; the other is the read bank.
  logic signed [ACC_BW-1:0] mem [0:1][0:N_MEL-1];
  logic                     wr_sel;

  // S1 pipeline registers.
  logic                     s1_vld;
  logic signed [PW-1:0]     s1_p1;
  logic signed [PW-1:0]     s1_p2;
  logic [IDX_BW-1:0]        s1_idx1;
  logic [IDX_BW-1:0]        s1_idx2;
  logic [1:0]               s1_num;
  logic                     s1_first;
  logic                     s1_last;

  logic signed [PROD_BW-1:0] d_ext;
  logic signed [PROD_BW-1:0] c1_ext;
  logic signed [PROD_BW-1:0] c2_ext;

  assign d_ext  = PROD_BW'(data_i);
  assign c1_ext = PROD_BW'(coef1);
  assign c2_ext = PROD_BW'(coef2);

  // S1: capture the floored products and the sample's metadata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld   <= 1'b0;
      s1_p1    <= '0;
      s1_p2    <= '0;
      s1_idx1  <= '0;
      s1_idx2  <= '0;
      s1_num   <= '0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_vld <= di_en;
      if (di_en) begin
        s1_p1    <= PW'((d_ext * c1_ext) >>> FRAC);
        s1_p2    <= PW'((d_ext * c2_ext) >>> FRAC);
        s1_idx1  <= coef_idx1;
        s1_idx2  <= coef_idx2;
        s1_num   <= coef_num;
        s1_first <= is_first_in;
        s1_last  <= is_last_in;
      end
    end
  end

  // Index range check. It is only needed when the index field can exceed N_MEL-1.
  logic ok1, ok2;
  if (N_MEL >= (1 << IDX_BW)) begin : g_idx_full
    assign ok1 = 1'b1;
    assign ok2 = 1'b1;
  end else begin : g_idx_part
    assign ok1 = (s1_idx1 < IDX_BW'(N_MEL));
    assign ok2 = (s1_idx2 < IDX_BW'(N_MEL));
  end

  logic signed [ACC_BW-1:0] base1, base2;
  logic signed [SUM_BW-1:0] b1_ext, b2_ext, p1_ext, p2_ext, add2, sum1, sum2;
  logic signed [ACC_BW-1:0] v1, v2;
  logic                     c1_clip, c2_clip, same, w1, w2;

  // S2: saturating sums for the one or two target filters.
  // A 'first' sample treats the old contents as zero.
  always_comb begin
    same   = (s1_idx1 == s1_idx2);
    w1     = s1_vld && ((s1_num == 2'd1) || (s1_num == 2'd2)) && ok1;
    w2     = s1_vld && (s1_num == 2'd2) && ok2 && !same;
    base1  = s1_first ? '0 : mem[wr_sel][s1_idx1];
    base2  = s1_first ? '0 : mem[wr_sel][s1_idx2];
    b1_ext = SUM_BW'(base1);
    b2_ext = SUM_BW'(base2);
    p1_ext = SUM_BW'(s1_p1);
    p2_ext = SUM_BW'(s1_p2);
    add2   = '0;
    if ((s1_num == 2'd2) && same) add2 = p2_ext;
    sum1   = b1_ext + p1_ext + add2;
    sum2   = b2_ext + p2_ext;
    v1      = ACC_BW'(sum1);
    c1_clip = 1'b0;
    if (sum1 > ACC_MAX) begin
      v1 = ACC_BW'(ACC_MAX);
      c1_clip = 1'b1;
    end else if (sum1 < ACC_MIN) begin
      v1 = ACC_BW'(ACC_MIN);
      c1_clip = 1'b1;
    end
    v2      = ACC_BW'(sum2);
    c2_clip = 1'b0;
    if (sum2 > ACC_MAX) begin
      v2 = ACC_BW'(ACC_MAX);
      c2_clip = 1'b1;
    end else if (sum2 < ACC_MIN) begin
      v2 = ACC_BW'(ACC_MIN);
      c2_clip = 1'b1;
    end
  end

  // S2: write-bank update. A 'first' sample clears the bank, then the hits land.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < N_MEL; i++)
          mem[b][i] <= '0;
    end else begin
      if (s1_vld && s1_first)
        for (int i = 0; i < N_MEL; i++)
          mem[wr_sel][i] <= '0;
      if (w1) mem[wr_sel][s1_idx1] <= v1;
      if (w2) mem[wr_sel][s1_idx2] <= v2;
    end
  end

  logic final_hs, swap_req, swap_ok, sat_set, ovf_set;

  assign final_hs = do_valid && do_ready && do_last;
  assign swap_req = s1_vld && s1_last;
  // The read bank frees up on the final handshake edge, so a swap on that edge is accepted.
  assign swap_ok  = swap_req && ((rd_state == RD_IDLE) || final_hs);
  assign ovf_set  = swap_req && !swap_ok;
  assign sat_set  = (w1 && c1_clip) || (w2 && c2_clip);

  assign data_o = mem[~wr_sel][do_mel_idx];

  // Readout FSM, bank swap, frame counter and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state   <= RD_IDLE;
      wr_sel     <= 1'b0;
      do_valid   <= 1'b0;
      do_mel_idx <= '0;
      do_last    <= 1'b0;
      frame_cnt  <= '0;
      ovf        <= 1'b0;
      sat        <= 1'b0;
    end else begin
      case (rd_state)
        RD_START: begin
          do_valid   <= 1'b1;
          do_mel_idx <= '0;
          do_last    <= (N_MEL == 1);
          rd_state   <= RD_READ;
        end
        RD_READ: begin
          if (do_valid && do_ready) begin
            if (do_last) begin
              do_valid  <= 1'b0;
              do_last   <= 1'b0;
              frame_cnt <= frame_cnt + 16'd1;
              rd_state  <= RD_IDLE;
            end else begin
              do_mel_idx <= do_mel_idx + 1'b1;
              do_last    <= (do_mel_idx == IDX_BW'(N_MEL - 2));
            end
          end
        end
        default: ;
      endcase
      if (swap_ok) begin
        wr_sel   <= ~wr_sel;
        rd_state <= RD_START;
      end
      ovf <= ovf_set || (ovf && !clr_flags);
      sat <= sat_set || (sat && !clr_flags);
    end
  end

endmodule

// File: tb/tb_mel_filter_acc.sv
// Testbench for mel_filter_acc. Directed frames go in with hand-computed
// filter values. Each expected frame is queued as 64 beats, and a monitor
// pops one beat per output handshake.
module tb_mel_filter_acc;

  localparam logic [26:0] C_ONE  = 27'd67108864; // 1.0
  localparam logic [26:0] C_HALF = 27'd33554432; // 0.5
  localparam logic [26:0] C_QTR  = 27'd16777216; // 0.25

  logic               clk = 1'b0;
  logic               rst;
  logic               di_en;
  logic signed [26:0] data_i;
  logic               is_first_in, is_last_in;
  logic [1:0]         coef_num;
  logic [5:0]         coef_idx1, coef_idx2;
  logic [26:0]        coef1, coef2;
  logic               do_valid, do_ready;
  logic signed [31:0] data_o;
  logic [5:0]         do_mel_idx;
  logic               do_last;
  logic [15:0]        frame_cnt;
  logic               ovf, sat, clr_flags;

  int checks = 0;
  int errors = 0;

  logic [38:0]        exp_q[$];
  logic signed [31:0] exp_frame[64];

  // Clock generation.
  always #5 clk = ~clk;

  mel_filter_acc dut (
    .clk(clk), .rst(rst), .di_en(di_en), .data_i(data_i),
    .is_first_in(is_first_in), .is_last_in(is_last_in),
    .coef_num(coef_num), .coef_idx1(coef_idx1), .coef_idx2(coef_idx2),
    .coef1(coef1), .coef2(coef2),
    .do_valid(do_valid), .do_ready(do_ready), .data_o(data_o),
    .do_mel_idx(do_mel_idx), .do_last(do_last),
    .frame_cnt(frame_cnt), .ovf(ovf), .sat(sat), .clr_flags(clr_flags)
  );

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic zero_frame();
    for (int i = 0; i < 64; i++) exp_frame[i] = '0;
  endtask

  task automatic push_frame();
    for (int i = 0; i < 64; i++)
      exp_q.push_back({(i == 63), 6'(i), exp_frame[i]});
  endtask

  task automatic send(input logic signed [26:0] d, input logic [1:0] n,
                      input logic [5:0] i1, input logic [5:0] i2,
                      input logic [26:0] k1, input logic [26:0] k2,
                      input logic f, input logic l);
    di_en = 1'b1; data_i = d; coef_num = n; coef_idx1 = i1; coef_idx2 = i2;
    coef1 = k1; coef2 = k2; is_first_in = f; is_last_in = l;
    @(posedge clk); #1;
  endtask

  task automatic idle();
    di_en = 1'b0; is_first_in = 1'b0; is_last_in = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n = 0;
    while (frame_cnt != 16'(target) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    check("frame_cnt", frame_cnt, target);
    check("queue_drained", exp_q.size(), 0);
  endtask

  task automatic wait_idx(input int idx);
    int n = 0;
    while (!(do_valid && do_mel_idx == 6'(idx)) && n < 1000) begin
      @(posedge clk); #1; n++;
    end
    check("reach_idx", do_mel_idx, idx);
  endtask

  // Monitor: compares every output beat with the expected queue and
  // checks that the outputs hold steady during a stall.
  initial begin
    logic [38:0] held;
    logic [38:0] got;
    logic [38:0] exp;
    logic        stalled;
    held = '0;
    stalled = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        stalled = 1'b0;
      end else begin
        got = {do_last, do_mel_idx, data_o};
        if (stalled) begin
          checks++;
          if (got !== held) begin
            errors++;
            $display("FAIL stall_hold actual=%h expected=%h", got, held);
          end
        end
        if (do_valid && do_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat actual=idx%0d data%0d expected=none",
                     do_mel_idx, data_o);
          end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
              errors++;
              $display("FAIL beat actual=last%0d idx%0d data%0d expected=last%0d idx%0d data%0d",
                       got[38], got[37:32], $signed(got[31:0]),
                       exp[38], exp[37:32], $signed(exp[31:0]));
            end
          end
        end
        stalled = do_valid && !do_ready;
        held = got;
      end
    end
  end

  // Overall time limit.
  initial begin
    #1000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  // Stimulus.
  initial begin
    int n;
    rst = 1'b0; di_en = 1'b0; data_i = '0; is_first_in = 1'b0; is_last_in = 1'b0;
    coef_num = '0; coef_idx1 = '0; coef_idx2 = '0; coef1 = '0; coef2 = '0;
    do_ready = 1'b1; clr_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_do_valid", do_valid, 0);
    check("rst_do_mel_idx", do_mel_idx, 0);
    check("rst_do_last", do_last, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_ovf", ovf, 0);
    check("rst_sat", sat, 0);
    check("rst_data_o", data_o, 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    // Frame 1: three bins of 1000 at weight 0.5 into filter 5.
    zero_frame(); exp_frame[5] = 1500; push_frame();
    send(27'sd1000, 2'd1, 6'd5, 6'd0, C_HALF, 27'd0, 1'b1, 1'b0);
    send(27'sd1000, 2'd1, 6'd5, 6'd0, C_HALF, 27'd0, 1'b0, 1'b0);
    send(27'sd1000, 2'd1, 6'd5, 6'd0, C_HALF, 27'd0, 1'b0, 1'b1);
    idle();
    n = 1;
    while (!do_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("latency", n, 3);
    wait_frames(1);

    // Frame 2: floored products, a shared index, ignored coef_num values, single weight.
    zero_frame();
    exp_frame[7] = -4; exp_frame[8] = -1; exp_frame[9] = 7; exp_frame[10] = -2;
    push_frame();
    send(-27'sd4, 2'd2, 6'd7, 6'd8, C_ONE, C_QTR, 1'b1, 1'b0);
    send(27'sd5, 2'd2, 6'd9, 6'd9, C_ONE, C_HALF, 1'b0, 1'b0);
    send(27'sd100, 2'd0, 6'd12, 6'd12, C_ONE, C_ONE, 1'b0, 1'b0);
    send(27'sd100, 2'd3, 6'd12, 6'd12, C_ONE, C_ONE, 1'b0, 1'b0);
    send(-27'sd3, 2'd1, 6'd10, 6'd13, C_HALF, C_ONE, 1'b0, 1'b1);
    idle();
    wait_frames(2);

    // Frame 3: the write bank still holds frame 1, so 'first' must clear it. do_ready toggles.
    zero_frame(); exp_frame[0] = 50; exp_frame[63] = 7; push_frame();
    send(27'sd50, 2'd1, 6'd0, 6'd0, C_ONE, 27'd0, 1'b1, 1'b0);
    send(27'sd7, 2'd1, 6'd63, 6'd0, C_ONE, 27'd0, 1'b0, 1'b1);
    idle();
    n = 0;
    while (frame_cnt != 16'd3 && n < 1000) begin
      @(posedge clk); #1; do_ready = ~do_ready; n++;
    end
    do_ready = 1'b1;
    check("frame_cnt_toggle", frame_cnt, 3);

    // Frame 4 is stalled at idx 10. Frame 5 ends while the read bank is busy and is dropped.
    zero_frame(); exp_frame[2] = 8; push_frame();
    send(27'sd8, 2'd1, 6'd2, 6'd0, C_ONE, 27'd0, 1'b1, 1'b1);
    idle();
    wait_idx(10);
    do_ready = 1'b0;
    send(27'sd99, 2'd1, 6'd4, 6'd0, C_ONE, 27'd0, 1'b1, 1'b1);
    idle();
    repeat (4) begin @(posedge clk); #1; end
    check("ovf_set", ovf, 1);
    check("stall_idx", do_mel_idx, 10);
    check("stall_valid", do_valid, 1);
    do_ready = 1'b1;
    wait_frames(4);
    repeat (10) begin @(posedge clk); #1; end
    check("dropped_no_valid", do_valid, 0);
    check("frame_cnt_after_drop", frame_cnt, 4);
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    check("ovf_clr", ovf, 0);

    // Frame 6: 64 back-to-back max bins into filter 0. The sum saturates.
    zero_frame(); exp_frame[0] = 32'sh7FFFFFFF; push_frame();
    for (int k = 0; k < 64; k++)
      send(27'sd67108863, 2'd1, 6'd0, 6'd0, C_ONE, 27'd0, (k == 0), (k == 63));
    idle();
    wait_frames(5);
    check("sat_set", sat, 1);
    check("ovf_quiet", ovf, 0);
    clr_flags = 1'b1;
    @(posedge clk); #1;
    clr_flags = 1'b0;
    check("sat_clr", sat, 0);

    // Frame 7 has no 'first' and adds onto frame 4's leftovers (filter 2 = 8).
    zero_frame(); exp_frame[2] = 9; push_frame();
    send(27'sd1, 2'd1, 6'd2, 6'd0, C_ONE, 27'd0, 1'b0, 1'b1);
    idle();
    wait_frames(6);

    // Frame 8: reset during readout at idx 20.
    zero_frame(); exp_frame[1] = 1; push_frame();
    send(27'sd1, 2'd1, 6'd1, 6'd0, C_ONE, 27'd0, 1'b1, 1'b1);
    idle();
    wait_idx(20);
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_valid", do_valid, 0);
    check("rst_mid_idx", do_mel_idx, 0);
    check("rst_mid_frame_cnt", frame_cnt, 0);
    @(negedge clk) rst = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    check("no_partial_after_rst", do_valid, 0);

    // Frame 9: a one-bin frame after reset.
    zero_frame(); exp_frame[3] = 9; push_frame();
    send(27'sd9, 2'd1, 6'd3, 6'd0, C_ONE, 27'd0, 1'b1, 1'b1);
    idle();
    wait_frames(1);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
